// File: rtl/rs_station_pkg.sv
// rs_station_pkg: shared constants for the reservation station slice.
//   - default sizing (entries, ROB tag width, data width)
//   - internal opcode codes carried through the station untouched
package rs_station_pkg;

   localparam int RS_DEPTH_DEF = 8;
   localparam int ROB_W_DEF    = 4;
   localparam int XLEN_DEF     = 32;
   localparam int OP_W         = 6;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   typedef enum logic [OP_W-1:0] {
      OP_NOP  = 6'd0,
      OP_ADD  = 6'd1,
      OP_SUB  = 6'd2,
      OP_AND  = 6'd3,
      OP_OR   = 6'd4,
      OP_XOR  = 6'd5,
      OP_SLL  = 6'd6,
      OP_SRL  = 6'd7,
      OP_SRA  = 6'd8,
      OP_SLT  = 6'd9,
      OP_SLTU = 6'd10,
      OP_BEQ  = 6'd16,
      OP_BNE  = 6'd17,
      OP_BLT  = 6'd18,
      OP_BGE  = 6'd19,
      OP_JAL  = 6'd24,
      OP_JALR = 6'd25,
      OP_LUI  = 6'd26
   } op_e;

endpackage

// File: rtl/rs_station_prio_enc.sv
// rs_prio_enc: lowest-set-bit priority encoder.
//   req  in  N   request vector
//   idx  out W   index of the lowest set bit (0 when none set)
//   any  out 1   at least one request bit set
module rs_prio_enc #(
   parameter int N = 8,
   localparam int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   output logic [W-1:0] idx,
   output logic         any
);

   // Scan high to low so the lowest set bit is the last one written.
   always_comb begin
      idx = '0;
      any = |req;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) idx = W'(i);
      end
   end

endmodule

// File: rtl/rs_station.sv
// rs_station: reservation station between dispatch and the ALU.
// Buffers ops with possibly pending operands, snoops the ALU and LSB result
// buses to capture operands by ROB tag, and issues one ready op per cycle.
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low freezes all state and outputs
//   flush               discard every entry
//   disp_*              dispatch request (op, rob tag, operand ready/value, imm)
//   full                no free entry (from current occupancy)
//   alu_cdb_*, lsb_cdb_* result broadcasts (valid, tag, value)
//   ex_*                registered issue to the ALU
module rs_station
   import rs_station_pkg::*;
#(
   parameter int RS_DEPTH = RS_DEPTH_DEF,
   parameter int ROB_W    = ROB_W_DEF,
   parameter int XLEN     = XLEN_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              flush,
   input  logic              disp_vld,
   input  logic [OP_W-1:0]   disp_op,
   input  logic [ROB_W-1:0]  disp_rob,
   input  logic              disp_r1,
   input  logic              disp_r2,
   input  logic [XLEN-1:0]   disp_v1,
   input  logic [XLEN-1:0]   disp_v2,
   input  logic [XLEN-1:0]   disp_imm,
   output logic              full,
   input  logic              alu_cdb_vld,
   input  logic [ROB_W-1:0]  alu_cdb_tag,
   input  logic [XLEN-1:0]   alu_cdb_val,
   input  logic              lsb_cdb_vld,
   input  logic [ROB_W-1:0]  lsb_cdb_tag,
   input  logic [XLEN-1:0]   lsb_cdb_val,
   output logic              ex_vld,
   output logic [OP_W-1:0]   ex_op,
   output logic [XLEN-1:0]   ex_v1,
   output logic [XLEN-1:0]   ex_v2,
   output logic [XLEN-1:0]   ex_imm,
   output logic [ROB_W-1:0]  ex_rob
);

   localparam int IW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

   logic [RS_DEPTH-1:0] busy;
   logic [RS_DEPTH-1:0] r1;
   logic [RS_DEPTH-1:0] r2;
   logic [OP_W-1:0]     op_q  [RS_DEPTH];
   logic [ROB_W-1:0]    rob_q [RS_DEPTH];
   logic [ROB_W-1:0]    q1    [RS_DEPTH];
   logic [ROB_W-1:0]    q2    [RS_DEPTH];
   logic [XLEN-1:0]     v1    [RS_DEPTH];
   logic [XLEN-1:0]     v2    [RS_DEPTH];
   logic [XLEN-1:0]     imm_q [RS_DEPTH];

   logic [RS_DEPTH-1:0] free_vec;
   logic [RS_DEPTH-1:0] ready_vec;
   logic [IW-1:0]       free_idx;
   logic [IW-1:0]       iss_idx;
   logic                free_any;
   logic                iss_any;

   assign free_vec  = ~busy;
   assign ready_vec = busy & r1 & r2;
   assign full      = &busy;

   rs_prio_enc #(.N(RS_DEPTH)) u_free_enc (
      .req (free_vec),
      .idx (free_idx),
      .any (free_any)
   );

   rs_prio_enc #(.N(RS_DEPTH)) u_iss_enc (
      .req (ready_vec),
      .idx (iss_idx),
      .any (iss_any)
   );

   // Insert bypass: a pending operand whose producer broadcasts in the
   // dispatch cycle is captured directly. ALU has precedence over LSB.
   logic              ins_r1, ins_r2;
   logic [XLEN-1:0]   ins_v1, ins_v2;
   logic [ROB_W-1:0]  ins_q1, ins_q2;

   always_comb begin
      ins_q1 = disp_v1[ROB_W-1:0];
      ins_q2 = disp_v2[ROB_W-1:0];
      ins_r1 = disp_r1;
      ins_r2 = disp_r2;
      ins_v1 = disp_v1;
      ins_v2 = disp_v2;
      if (!disp_r1) begin
         if (alu_cdb_vld && alu_cdb_tag == ins_q1) begin
            ins_r1 = TRUE;
            ins_v1 = alu_cdb_val;
         end else if (lsb_cdb_vld && lsb_cdb_tag == ins_q1) begin
            ins_r1 = TRUE;
            ins_v1 = lsb_cdb_val;
         end
      end
      if (!disp_r2) begin
         if (alu_cdb_vld && alu_cdb_tag == ins_q2) begin
            ins_r2 = TRUE;
            ins_v2 = alu_cdb_val;
         end else if (lsb_cdb_vld && lsb_cdb_tag == ins_q2) begin
            ins_r2 = TRUE;
            ins_v2 = lsb_cdb_val;
         end
      end
   end

   // Issue pick, wakeup and dispatch all use pre-edge state, so the slot
   // freed by an issue is never the one picked for a same-cycle dispatch.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy   <= '0;
         ex_vld <= FALSE;
         ex_op  <= '0;
         ex_v1  <= '0;
         ex_v2  <= '0;
         ex_imm <= '0;
         ex_rob <= '0;
      end else if (flush) begin
         busy   <= '0;
         ex_vld <= FALSE;
      end else if (rdy) begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            if (busy[i] && !r1[i]) begin
               if (alu_cdb_vld && alu_cdb_tag == q1[i]) begin
                  r1[i] <= TRUE;
                  v1[i] <= alu_cdb_val;
               end else if (lsb_cdb_vld && lsb_cdb_tag == q1[i]) begin
                  r1[i] <= TRUE;
                  v1[i] <= lsb_cdb_val;
               end
            end
            if (busy[i] && !r2[i]) begin
               if (alu_cdb_vld && alu_cdb_tag == q2[i]) begin
                  r2[i] <= TRUE;
                  v2[i] <= alu_cdb_val;
               end else if (lsb_cdb_vld && lsb_cdb_tag == q2[i]) begin
                  r2[i] <= TRUE;
                  v2[i] <= lsb_cdb_val;
               end
            end
         end

         ex_vld <= iss_any;
         if (iss_any) begin
            ex_op         <= op_q[iss_idx];
            ex_v1         <= v1[iss_idx];
            ex_v2         <= v2[iss_idx];
            ex_imm        <= imm_q[iss_idx];
            ex_rob        <= rob_q[iss_idx];
            busy[iss_idx] <= FALSE;
         end

         if (disp_vld && !full && free_any) begin
            busy[free_idx]  <= TRUE;
            op_q[free_idx]  <= disp_op;
            rob_q[free_idx] <= disp_rob;
            imm_q[free_idx] <= disp_imm;
            q1[free_idx]    <= ins_q1;
            q2[free_idx]    <= ins_q2;
            r1[free_idx]    <= ins_r1;
            r2[free_idx]    <= ins_r2;
            v1[free_idx]    <= ins_v1;
            v2[free_idx]    <= ins_v2;
         end
      end
   end

endmodule

// File: tb/tb_rs_station.sv
// tb_rs_station: directed vectors with hand-computed expectations for rs_station.
module tb_rs_station;
   import rs_station_pkg::*;

   logic        clk = 1'b0;
   logic        rst, rdy, flush;
   logic        disp_vld, disp_r1, disp_r2;
   logic [5:0]  disp_op;
   logic [3:0]  disp_rob;
   logic [31:0] disp_v1, disp_v2, disp_imm;
   logic        full;
   logic        alu_cdb_vld, lsb_cdb_vld;
   logic [3:0]  alu_cdb_tag, lsb_cdb_tag;
   logic [31:0] alu_cdb_val, lsb_cdb_val;
   logic        ex_vld;
   logic [5:0]  ex_op;
   logic [31:0] ex_v1, ex_v2, ex_imm;
   logic [3:0]  ex_rob;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   rs_station dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .disp_vld(disp_vld), .disp_op(disp_op), .disp_rob(disp_rob),
      .disp_r1(disp_r1), .disp_r2(disp_r2), .disp_v1(disp_v1), .disp_v2(disp_v2),
      .disp_imm(disp_imm), .full(full),
      .alu_cdb_vld(alu_cdb_vld), .alu_cdb_tag(alu_cdb_tag), .alu_cdb_val(alu_cdb_val),
      .lsb_cdb_vld(lsb_cdb_vld), .lsb_cdb_tag(lsb_cdb_tag), .lsb_cdb_val(lsb_cdb_val),
      .ex_vld(ex_vld), .ex_op(ex_op), .ex_v1(ex_v1), .ex_v2(ex_v2),
      .ex_imm(ex_imm), .ex_rob(ex_rob)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_disp(input logic [3:0] rob, input logic r1, input logic [31:0] v1,
                           input logic r2, input logic [31:0] v2);
      disp_vld = 1'b1;
      disp_op  = 6'(OP_ADD);
      disp_rob = rob;
      disp_r1  = r1;
      disp_v1  = v1;
      disp_r2  = r2;
      disp_v2  = v2;
      disp_imm = {28'h0000100, rob};
   endtask

   task automatic no_disp();
      disp_vld = 1'b0;
   endtask

   task automatic alu(input logic [3:0] tag, input logic [31:0] val);
      alu_cdb_vld = 1'b1;
      alu_cdb_tag = tag;
      alu_cdb_val = val;
   endtask

   task automatic lsb(input logic [3:0] tag, input logic [31:0] val);
      lsb_cdb_vld = 1'b1;
      lsb_cdb_tag = tag;
      lsb_cdb_val = val;
   endtask

   task automatic cdb_idle();
      alu_cdb_vld = 1'b0;
      lsb_cdb_vld = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; flush = 1'b0;
      disp_vld = 1'b0; disp_op = '0; disp_rob = '0; disp_r1 = 1'b0; disp_r2 = 1'b0;
      disp_v1 = '0; disp_v2 = '0; disp_imm = '0;
      alu_cdb_vld = 1'b0; alu_cdb_tag = '0; alu_cdb_val = '0;
      lsb_cdb_vld = 1'b0; lsb_cdb_tag = '0; lsb_cdb_val = '0;
      tick();
      tick();
      chk("rst_ex_vld", 64'(ex_vld), 64'd0);
      chk("rst_full",   64'(full),   64'd0);
      chk("rst_ex_op",  64'(ex_op),  64'd0);
      chk("rst_ex_v1",  64'(ex_v1),  64'd0);
      chk("rst_ex_v2",  64'(ex_v2),  64'd0);
      chk("rst_ex_imm", 64'(ex_imm), 64'd0);
      chk("rst_ex_rob", 64'(ex_rob), 64'd0);
      rst = 1'b0;

      // ready ADD: one cycle in the station, then issue
      set_disp(4'd3, 1'b1, 32'd5, 1'b1, 32'd7);
      tick();
      no_disp();
      chk("t1_latency", 64'(ex_vld), 64'd0);
      tick();
      chk("t1_vld", 64'(ex_vld), 64'd1);
      chk("t1_op",  64'(ex_op),  64'(OP_ADD));
      chk("t1_v1",  64'(ex_v1),  64'd5);
      chk("t1_v2",  64'(ex_v2),  64'd7);
      chk("t1_rob", 64'(ex_rob), 64'd3);
      chk("t1_imm", 64'(ex_imm), 64'h1003);
      tick();
      chk("t1_cleared", 64'(ex_vld), 64'd0);

      // pending q1=6 woken by ALU three cycles later
      set_disp(4'd4, 1'b0, 32'd6, 1'b1, 32'd1);
      tick();
      no_disp();
      tick();
      tick();
      alu(4'd6, 32'h10);
      tick();
      cdb_idle();
      chk("t2_wait", 64'(ex_vld), 64'd0);
      tick();
      chk("t2_vld", 64'(ex_vld), 64'd1);
      chk("t2_v1",  64'(ex_v1),  64'h10);
      chk("t2_rob", 64'(ex_rob), 64'd4);

      // insert bypass from LSB
      set_disp(4'd5, 1'b1, 32'd2, 1'b0, 32'd9);
      lsb(4'd9, 32'hAB);
      tick();
      no_disp();
      cdb_idle();
      tick();
      chk("t3_vld", 64'(ex_vld), 64'd1);
      chk("t3_v2",  64'(ex_v2),  64'hAB);
      chk("t3_v1",  64'(ex_v1),  64'd2);
      chk("t3_rob", 64'(ex_rob), 64'd5);

      // same tag on both buses: ALU wins; then LSB wakeup of q2
      set_disp(4'd6, 1'b0, 32'd5, 1'b0, 32'd7);
      tick();
      no_disp();
      alu(4'd5, 32'h55);
      lsb(4'd5, 32'h66);
      tick();
      cdb_idle();
      lsb(4'd7, 32'h77);
      tick();
      cdb_idle();
      chk("t3b_wait", 64'(ex_vld), 64'd0);
      tick();
      chk("t3b_vld", 64'(ex_vld), 64'd1);
      chk("t3b_v1",  64'(ex_v1),  64'h55);
      chk("t3b_v2",  64'(ex_v2),  64'h77);
      tick();

      // fill all 8 entries with blocked ops (slot i waits on tag i)
      for (int i = 0; i < 8; i++) begin
         set_disp(4'(i), 1'b0, 32'(i), 1'b1, 32'd0);
         tick();
         if (i == 6) chk("t4_not_full_7", 64'(full), 64'd0);
      end
      no_disp();
      chk("t4_full", 64'(full), 64'd1);
      chk("t4_no_issue", 64'(ex_vld), 64'd0);
      set_disp(4'd15, 1'b1, 32'd1, 1'b1, 32'd1);
      tick();
      no_disp();
      tick();
      chk("t4_drop", 64'(ex_vld), 64'd0);
      alu(4'd2, 32'h22);
      tick();
      cdb_idle();
      chk("t4_full_woken", 64'(full), 64'd1);
      tick();
      chk("t4_vld", 64'(ex_vld), 64'd1);
      chk("t4_rob", 64'(ex_rob), 64'd2);
      chk("t4_v1",  64'(ex_v1),  64'h22);
      chk("t4_full_after", 64'(full), 64'd0);
      tick();
      chk("t4_drop_gone", 64'(ex_vld), 64'd0);

      // occupancy 7 + dispatch + issue stays at 7
      alu(4'd3, 32'h33);
      tick();
      cdb_idle();
      set_disp(4'd12, 1'b0, 32'd12, 1'b1, 32'd0);
      tick();
      chk("t4b_vld", 64'(ex_vld), 64'd1);
      chk("t4b_rob", 64'(ex_rob), 64'd3);
      chk("t4b_full7", 64'(full), 64'd0);
      set_disp(4'd13, 1'b0, 32'd13, 1'b1, 32'd0);
      tick();
      no_disp();
      chk("t4b_full8", 64'(full), 64'd1);
      do_flush();
      chk("t4b_flush_full", 64'(full), 64'd0);

      // slots 1,4,6 wait on tag 10, others on tag 11
      for (int i = 0; i < 7; i++) begin
         set_disp(4'(i), 1'b0, (i == 1 || i == 4 || i == 6) ? 32'd10 : 32'd11, 1'b1, 32'(i));
         tick();
      end
      no_disp();
      alu(4'd10, 32'hA0);
      tick();
      cdb_idle();
      tick();
      chk("t5_vld_a", 64'(ex_vld), 64'd1);
      chk("t5_rob_a", 64'(ex_rob), 64'd1);
      tick();
      chk("t5_vld_b", 64'(ex_vld), 64'd1);
      chk("t5_rob_b", 64'(ex_rob), 64'd4);
      tick();
      chk("t5_vld_c", 64'(ex_vld), 64'd1);
      chk("t5_rob_c", 64'(ex_rob), 64'd6);
      chk("t5_v1_c",  64'(ex_v1),  64'hA0);
      tick();
      chk("t5_done", 64'(ex_vld), 64'd0);

      // flush with 5 busy (slot 1 ready) and a same-cycle dispatch
      set_disp(4'd7, 1'b1, 32'd1, 1'b1, 32'd1);
      tick();
      flush = 1'b1;
      set_disp(4'd8, 1'b1, 32'd1, 1'b1, 32'd1);
      tick();
      flush = 1'b0;
      no_disp();
      chk("t6_vld", 64'(ex_vld), 64'd0);
      chk("t6_full", 64'(full), 64'd0);
      tick();
      chk("t6_disp_dropped", 64'(ex_vld), 64'd0);
      alu(4'd11, 32'hB0);
      tick();
      cdb_idle();
      tick();
      chk("t6_stale_a", 64'(ex_vld), 64'd0);
      tick();
      chk("t6_stale_b", 64'(ex_vld), 64'd0);

      // rdy=0 for 3 cycles holds ex_* and blocks dispatch
      set_disp(4'd9, 1'b1, 32'h99, 1'b1, 32'd0);
      tick();
      set_disp(4'd10, 1'b1, 32'hAA, 1'b1, 32'd0);
      tick();
      chk("t7_rob_a", 64'(ex_rob), 64'd9);
      set_disp(4'd11, 1'b1, 32'hBB, 1'b1, 32'd0);
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t7_hold_vld", 64'(ex_vld), 64'd1);
         chk("t7_hold_rob", 64'(ex_rob), 64'd9);
         chk("t7_hold_v1",  64'(ex_v1),  64'h99);
      end
      no_disp();
      rdy = 1'b1;
      tick();
      chk("t7_rob_b", 64'(ex_rob), 64'd10);
      chk("t7_v1_b",  64'(ex_v1),  64'hAA);
      tick();
      chk("t7_done", 64'(ex_vld), 64'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
